// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle instruction sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It handshakes
// with the instruction and data memories and drives the datapath enables and
// mux selects.
// Optional feature: define MEM_TIMEOUT_EN to add a memory-ack watchdog that
// halts the sequencer after TIMEOUT_CYCLES cycles without an ack.
module multicycle_seq #(
  parameter int OPCODE_W       = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                branch_taken,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_load_en,
  output logic                pc_write_en,
  output logic [1:0]          pc_src,
  output logic                reg_write_en,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic                timeout,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_IALU, CL_LOAD, CL_STORE,
    CL_BRANCH, CL_AUIPC, CL_LUI, CL_JAL, CL_JALR
  } class_t;

  state_t state_reg;
  class_t class_reg;
  class_t class_next;
  logic   illegal_reg;
  logic   wait_limit;   // a memory wait has run out of budget this cycle

  assign state = state_reg;

  // Classify the IR opcode; anything outside the supported set maps to CL_NONE
  always_comb begin
    case (opcode)
      OPCODE_W'(7'b0110011): class_next = CL_R;
      OPCODE_W'(7'b0010011): class_next = CL_IALU;
      OPCODE_W'(7'b0000011): class_next = CL_LOAD;
      OPCODE_W'(7'b1100111): class_next = CL_JALR;
      OPCODE_W'(7'b0100011): class_next = CL_STORE;
      OPCODE_W'(7'b1100011): class_next = CL_BRANCH;
      OPCODE_W'(7'b0010111): class_next = CL_AUIPC;
      OPCODE_W'(7'b0110111): class_next = CL_LUI;
      OPCODE_W'(7'b1101111): class_next = CL_JAL;
      default:               class_next = CL_NONE;
    endcase
  end

  // Sequencer state, latched instruction class and sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      class_reg   <= CL_NONE;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: state_reg <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack)        state_reg <= ST_DECODE;
          else if (wait_limit) state_reg <= ST_HALT;
        end
        ST_DECODE: begin
          // opcode is only looked at here; the class register carries it onward
          class_reg <= class_next;
          if (class_next == CL_NONE) begin
            illegal_reg <= 1'b1;
            state_reg   <= ST_HALT;
          end else begin
            state_reg   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (class_reg == CL_LOAD || class_reg == CL_STORE) state_reg <= ST_MEM;
          else if (class_reg == CL_BRANCH)                   state_reg <= ST_FETCH;
          else                                               state_reg <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ack)        state_reg <= (class_reg == CL_STORE) ? ST_FETCH : ST_WB;
          else if (wait_limit) state_reg <= ST_HALT;
        end
        ST_WB:   state_reg <= ST_FETCH;
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_reg;
  logic             waiting;

  assign waiting    = ((state_reg == ST_FETCH) && !imem_ack) ||
                      ((state_reg == ST_MEM)   && !dmem_ack);
  // The count reaching the limit this cycle means TIMEOUT_CYCLES ack-less cycles
  assign wait_limit = waiting && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_reg;

  // Watchdog: count ack-less request cycles, restart whenever no wait is pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (wait_limit) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b1;
    end else if (waiting) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = &{1'b0, 32'(TIMEOUT_CYCLES)};
  assign wait_limit = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Datapath controls decoded from the current state and latched class
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_load_en   = 1'b0;
    pc_write_en  = 1'b0;
    pc_src       = 2'b00;
    reg_write_en = 1'b0;
    wb_sel       = 2'b00;
    case (state_reg)
      ST_FETCH: begin
        imem_req   = 1'b1;
        ir_load_en = imem_ack;
      end
      ST_EXEC: begin
        if (class_reg == CL_BRANCH) begin
          pc_write_en = 1'b1;
          pc_src      = branch_taken ? 2'b01 : 2'b00;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_reg == CL_STORE);
        // a completed store retires straight to PC+4
        if (dmem_ack && class_reg == CL_STORE) pc_write_en = 1'b1;
      end
      ST_WB: begin
        reg_write_en = 1'b1;
        pc_write_en  = 1'b1;
        if (class_reg == CL_LOAD)                           wb_sel = 2'b01;
        else if (class_reg == CL_JAL || class_reg == CL_JALR) wb_sel = 2'b10;
        if (class_reg == CL_JAL)       pc_src = 2'b01;
        else if (class_reg == CL_JALR) pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_seq.sv
// Testbench for multicycle_seq: randomized instruction stream with random
// memory wait states, checked cycle by cycle against an instruction-level
// reference model that expands each instruction into its expected trace.
module tb_multicycle_seq;

  localparam int TO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       branch_taken = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_load_en, pc_write_en;
  logic [1:0] pc_src;
  logic       reg_write_en;
  logic [1:0] wb_sel;
  logic       illegal, timeout;
  logic [2:0] state;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_illegal = 1'b0;
  logic exp_timeout = 1'b0;

  multicycle_seq #(.OPCODE_W(7), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load_en(ir_load_en), .pc_write_en(pc_write_en), .pc_src(pc_src),
    .reg_write_en(reg_write_en), .wb_sel(wb_sel),
    .illegal(illegal), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Instruction class from the opcode table: 0 = unsupported
  function automatic int classify(input logic [6:0] op);
    case (op)
      OP_R:      return 1;
      OP_IALU:   return 2;
      OP_LOAD:   return 3;
      OP_STORE:  return 4;
      OP_BRANCH: return 5;
      OP_AUIPC:  return 6;
      OP_LUI:    return 7;
      OP_JAL:    return 8;
      OP_JALR:   return 9;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [12:0] outs();
    return {imem_req, dmem_req, dmem_we, ir_load_en, pc_write_en, pc_src,
            reg_write_en, wb_sel, illegal, timeout};
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, checks, moves to the next falling edge
  task automatic cyc(input string tag, input int es,
                     input logic eir, input logic edr, input logic ewe, input logic eirl,
                     input logic epcw, input logic [1:0] epcs, input logic erw, input logic [1:0] ewbs,
                     input logic ia, input logic da, input logic bt, input logic [6:0] op);
    logic [12:0] ev;
    imem_ack = ia;
    dmem_ack = da;
    branch_taken = bt;
    opcode = op;
    #1;
    ev = {eir, edr, ewe, eirl, epcw, epcs, erw, ewbs, exp_illegal, exp_timeout};
    check_val({tag, "_state"}, 32'(state), 32'(es));
    check_val({tag, "_outs"}, 32'(outs()), 32'(ev));
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge, checks the cleared outputs, then releases into IDLE
  task automatic do_reset();
    rst = 1'b0;
    exp_illegal = 1'b0;
    exp_timeout = 1'b0;
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, rb(), rb(), rb(), rop());
  endtask

  // Expected trace of one instruction starting in FETCH
  task automatic run_instr(input logic [6:0] op, input logic bt, input int iw, input int dw);
    int c;
    logic st;
    logic [1:0] wbs, pcs;
    c = classify(op);
    $display("[TB] instr op=%b cls=%0d bt=%0d iw=%0d dw=%0d", op, c, bt, iw, dw);
    for (int i = 0; i < iw; i++)
      cyc("fetch_wait", 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1'b0, rb(), rb(), rop());
    cyc("fetch_ack", 1, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1'b1, rb(), rb(), rop());
    cyc("decode", 2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, rb(), rb(), rb(), op);
    if (c == 0) begin
      exp_illegal = 1'b1;
      for (int i = 0; i < 4; i++)
        cyc("halt", 7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, rb(), rb(), rb(), rop());
      return;
    end
    if (c == 5) begin
      cyc("exec_br", 3, 0, 0, 0, 0, 1, bt ? 2'b01 : 2'b00, 0, 2'b00, rb(), rb(), bt, rop());
      return;
    end
    cyc("exec", 3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, rb(), rb(), rb(), rop());
    if (c == 3 || c == 4) begin
      st = (c == 4);
      for (int i = 0; i < dw; i++)
        cyc("mem_wait", 4, 0, 1, st, 0, 0, 2'b00, 0, 2'b00, rb(), 1'b0, rb(), rop());
      cyc("mem_ack", 4, 0, 1, st, 0, st, 2'b00, 0, 2'b00, rb(), 1'b1, rb(), rop());
      if (st) return;
    end
    wbs = (c == 3) ? 2'b01 : ((c == 8 || c == 9) ? 2'b10 : 2'b00);
    pcs = (c == 8) ? 2'b01 : ((c == 9) ? 2'b10 : 2'b00);
    cyc("wb", 5, 0, 0, 0, 0, 1, pcs, 1, wbs, rb(), rb(), rb(), rop());
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    legal_ops = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_AUIPC, OP_LUI, OP_JAL, OP_JALR};
    repeat (2) @(negedge clk);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    do_reset();

    // directed instructions
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LOAD, 1'b0, 0, 3);
    run_instr(OP_BRANCH, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 1'b0, 0, 0);
    run_instr(OP_JAL, 1'b0, 0, 0);
    run_instr(OP_JALR, 1'b0, 0, 0);
    run_instr(OP_STORE, 1'b0, 1, 2);

    // random stream
    for (int n = 0; n < 60; n++)
      run_instr(legal_ops[$urandom_range(0, 8)], rb(), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));

    // reset in the middle of an instruction fetch
    $display("[TB] reset during fetch");
    imem_ack = 1'b0;
    #1;
    check_val("midrst_req_before", 32'(imem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_req_after", 32'(imem_req), 32'd0);
    check_val("midrst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, rb(), rb(), rb(), rop());
    run_instr(OP_IALU, 1'b0, 0, 0);

`ifdef MEM_TIMEOUT_EN
    // ack on the limit cycle wins over the watchdog
    run_instr(OP_LUI, 1'b0, TO - 1, TO - 1);
    run_instr(OP_LOAD, 1'b0, 0, TO - 1);
    $display("[TB] fetch watchdog");
    for (int i = 0; i < TO; i++)
      cyc("to_wait", 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1'b0, rb(), rb(), rop());
    exp_timeout = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("to_halt", 7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, rb(), rb(), rb(), rop());
    do_reset();
`else
    // no watchdog: a long fetch stall just waits
    run_instr(OP_AUIPC, 1'b0, 300, 0);
`endif

    // unsupported opcode halts until reset
    run_instr(7'b0000000, 1'b0, 0, 0);
    do_reset();
    run_instr(OP_R, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
